// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner with debounce, single-shot press reporting and hex digit entry.
// Optional build macro KEYPAD_EDIT_EN makes code 0xE clear the value and 0xF act as backspace.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  key_col,
  input  logic        clr,
  output logic [3:0]  key_row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] num_out
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebPress, StHold, StDebRel} state_e;

  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      col_meta_q, scol_q;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_down_q, key_down_d;
  logic [31:0]     num_q, num_d;
  logic [1:0]      low_col;
  logic            any_low;

  function automatic logic [31:0] digit_update(input logic [31:0] num, input logic [3:0] code);
`ifdef KEYPAD_EDIT_EN
    case (code)
      4'hE:    return 32'h0;
      4'hF:    return {4'h0, num[31:4]};
      default: return {num[27:0], code};
    endcase
`else
    return {num[27:0], code};
`endif
  endfunction

  // Lowest-index low column wins when several keys in the driven row are down.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!scol_q[i]) low_col = 2'(i);
    end
  end

  assign any_low = (scol_q != 4'hF);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    num_d       = num_q;

    unique case (state_q)
      StScan: begin
        // Columns are only trusted once the synchroniser has caught up with the new row.
        if (div_q == DivLast) begin
          div_d = '0;
          if (any_low) begin
            state_d = StDebPress;
            col_d   = low_col;
            cnt_d   = '0;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StDebPress: begin
        if (scol_q[col_q]) begin
          state_d = StScan;
          row_d   = row_q + 2'd1;
          div_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d     = StHold;
          key_valid_d = 1'b1;
          key_code_d  = {row_q, col_q};
          key_down_d  = 1'b1;
          num_d       = digit_update(num_q, {row_q, col_q});
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (scol_q == 4'hF) begin
          state_d = StDebRel;
          cnt_d   = '0;
        end
      end
      StDebRel: begin
        if (any_low) begin
          state_d = StHold;
        end else if (cnt_q == CntLast) begin
          state_d    = StScan;
          key_down_d = 1'b0;
          row_d      = row_q + 2'd1;
          div_d      = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StScan;
    endcase

    if (!en) begin
      state_d     = StScan;
      row_d       = 2'd0;
      div_d       = '0;
      cnt_d       = '0;
      key_down_d  = 1'b0;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      num_d       = num_q;
    end

    // A CPU clear beats a digit landing in the same cycle.
    if (clr) num_d = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StScan;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      div_q       <= '0;
      cnt_q       <= '0;
      col_meta_q  <= 4'hF;
      scol_q      <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_down_q  <= 1'b0;
      num_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      col_meta_q  <= key_col;
      scol_q      <= col_meta_q;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      num_q       <= num_d;
    end
  end

  assign key_row   = en ? ~(4'b0001 << row_q) : 4'hF;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
  assign num_out   = num_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, press scoreboard, table of digit entries.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [3:0]  key_col, key_row, key_code;
  logic        key_valid, key_down;
  logic [31:0] num_out;
  logic [15:0] pressed;

  typedef struct packed {logic [3:0] code; logic [31:0] num;} exp_t;
  typedef struct {logic [3:0] code; logic [31:0] num;} vec_t;

  exp_t        q[$];
  vec_t        tbl[9];
  int          errors = 0;
  int          checks = 0;
  int          pulse_cnt = 0;
  logic [31:0] model_num = 32'h0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .key_col   (key_col),
    .clr       (clr),
    .key_row   (key_row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .num_out   (num_out)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its column low only while its row is driven low.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r+c] && !key_row[r]) key_col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] next_num(input logic [31:0] num, input logic [3:0] code);
`ifdef KEYPAD_EDIT_EN
    if (code == 4'hE) return 32'h0;
    if (code == 4'hF) return num >> 4;
`endif
    return (num << 4) | {28'h0, code};
  endfunction

  always @(negedge clk) begin
    if (rst_n && key_valid === 1'b1) begin
      exp_t e;
      pulse_cnt++;
      if (q.size() == 0) begin
        check("unexpected_pulse", {28'h0, key_code}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("pulse_code", {28'h0, key_code}, {28'h0, e.code});
        check("pulse_num", num_out, e.num);
      end
    end
  end

  task automatic wait_pulse(input int target);
    int n = 0;
    while (pulse_cnt < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pulse_seen", pulse_cnt, target);
  endtask

  task automatic press_key(input logic [3:0] code);
    exp_t e;
    int   n;
    int   target;
    model_num = next_num(model_num, code);
    e.code = code;
    e.num  = model_num;
    q.push_back(e);
    target  = pulse_cnt + 1;
    pressed = 16'h1 << code;
    wait_pulse(target);
    repeat (3) @(negedge clk);
    check("held_down", {31'h0, key_down}, 32'h1);
    pressed = 16'h0;
    n = 0;
    while (key_down !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("released", {31'h0, key_down}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // Returns at the first negedge on which the scan has just moved onto the target row.
  task automatic wait_row(input logic [3:0] target);
    logic [3:0] prev;
    int         n = 0;
    prev = key_row;
    @(negedge clk);
    while (!(key_row == target && prev != target) && n < 40) begin
      prev = key_row;
      @(negedge clk);
      n++;
    end
    check("row_sync", {28'h0, key_row}, {28'h0, target});
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_num = 32'h0;
    check("clr_num", num_out, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    tbl = '{'{4'h1, 32'h1}, '{4'h2, 32'h12}, '{4'h3, 32'h123}, '{4'h4, 32'h1234},
            '{4'h5, 32'h12345}, '{4'h6, 32'h123456}, '{4'h7, 32'h1234567},
            '{4'h8, 32'h12345678}, '{4'h9, 32'h23456789}};
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; pressed = 16'h0;

    // Reset values and idle scan.
    repeat (2) @(negedge clk);
    check("rst_row", {28'h0, key_row}, 32'hE);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_code", {28'h0, key_code}, 32'h0);
    check("rst_down", {31'h0, key_down}, 32'h0);
    check("rst_num", num_out, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << (((i + 1) / 4) % 4));
      check("scan_row", {28'h0, key_row}, {28'h0, exp_row});
    end
    check("idle_pulses", pulse_cnt, 0);

    // Hold key 6 for 40 cycles, then release and time key_down.
    begin
      exp_t e;
      e.code = 4'h6; e.num = 32'h6;
      q.push_back(e);
      model_num = 32'h6;
      pressed = 16'h1 << 6;
      repeat (40) @(negedge clk);
      check("hold_pulses", pulse_cnt, 1);
      check("hold_down", {31'h0, key_down}, 32'h1);
      pressed = 16'h0;
      repeat (9) @(negedge clk);
      check("rel_down_high", {31'h0, key_down}, 32'h1);
      repeat (4) @(negedge clk);
      check("rel_down_low", {31'h0, key_down}, 32'h0);
    end

    // 3-cycle glitch on row0/col0 must be rejected and scan moves to row1.
    wait_row(4'b1110);
    pressed = 16'h1;
    repeat (3) @(negedge clk);
    pressed = 16'h0;
    repeat (4) @(negedge clk);
    check("glitch_row", {28'h0, key_row}, 32'hD);
    check("glitch_pulses", pulse_cnt, 1);

    // en low while a key is held.
    pressed = 16'h1 << 3;
    begin
      exp_t e;
      model_num = next_num(model_num, 4'h3);
      e.code = 4'h3; e.num = model_num;
      q.push_back(e);
    end
    wait_pulse(2);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_row", {28'h0, key_row}, 32'hF);
    check("en_down", {31'h0, key_down}, 32'h0);
    check("en_num", num_out, 32'h63);
    check("en_code", {28'h0, key_code}, 32'h3);
    pressed = 16'h0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_restart_row", {28'h0, key_row}, 32'hE);

    // Keys 1..9 from a cleared value.
    do_clr();
    p0 = pulse_cnt;
    for (int i = 0; i < 9; i++) begin
      press_key(tbl[i].code);
      check("tbl_num", num_out, tbl[i].num);
    end
    check("tbl_pulses", pulse_cnt - p0, 9);

    // clr lands on the same edge that accepts key 5.
    do_clr();
    press_key(4'h1);
    press_key(4'h2);
    check("pre_clr_num", num_out, 32'h12);
    begin
      exp_t e;
      e.code = 4'h5; e.num = 32'h0;
      q.push_back(e);
      model_num = 32'h0;
    end
    wait_row(4'b1101);
    pressed = 16'h1 << 5;
    repeat (11) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("accept_latency", {31'h0, key_valid}, 32'h1);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_race_num", num_out, 32'h0);
    check("clr_race_code", {28'h0, key_code}, 32'h5);
    pressed = 16'h0;
    repeat (20) @(negedge clk);
    check("clr_race_down", {31'h0, key_down}, 32'h0);

    // Edit keys.
    do_clr();
    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    check("edit_base", num_out, 32'h1234);
    press_key(4'hF);
`ifdef KEYPAD_EDIT_EN
    check("edit_bksp", num_out, 32'h123);
`else
    check("edit_bksp", num_out, 32'h1234F);
`endif
    press_key(4'hE);
`ifdef KEYPAD_EDIT_EN
    check("edit_clear", num_out, 32'h0);
`else
    check("edit_clear", num_out, 32'h1234FE);
`endif
    check("edit_code", {28'h0, key_code}, 32'hE);

    // Reset in the middle of a row2 press debounce.
    wait_row(4'b1011);
    pressed = 16'h1 << 8;
    repeat (6) @(negedge clk);
    check("pre_rst_row", {28'h0, key_row}, 32'hB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", {28'h0, key_row}, 32'hE);
    check("mid_rst_num", num_out, 32'h0);
    check("mid_rst_code", {28'h0, key_code}, 32'h0);
    check("mid_rst_down", {31'h0, key_down}, 32'h0);
    pressed = 16'h0;
    model_num = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    check("total_pulses", pulse_cnt, 20);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
